// File: rtl/cam_wr_sched.sv
// cam_wr_sched -- camera-side SDRAM write scheduler (133 MHz domain).
//
// Frames each camera picture on the falling edge of cmos_vsyn, clears the
// camera write FIFO, latches the target bank, then issues one row-burst
// request per row through the req/ack handshake until MAX_ROWS rows have
// been written. Per-frame row counts and a sticky overflow flag are reported.
//
// Ports:
//   clk_133M_i          in   133 MHz clock, rising edge
//   rst_133i            in   synchronous reset, active low
//   cmos_vsyn           in   raw camera VSYNC (asynchronous)
//   cam_bank      [1:0] in   bank for the next frame, sampled at frame start
//   fifo_used    [10:0] in   write-FIFO read-side fill level
//   wr_sdram_ack        in   burst-complete pulse from the SDRAM controller
//   wr_sdram_req        out  burst request (level)
//   wr_sdram_add [23:0] out  {bank, row, 9'b0}
//   clear_wrsdram_fifo  out  write-FIFO clear
//   frame_done          out  one-cycle pulse at each frame boundary after the first
//   rows_last    [12:0] out  row bursts completed in the previous frame
//   drop_flag           out  sticky: data arrived after the row limit was reached
module cam_wr_sched #(
   parameter int BURST_WORDS = 512,
   parameter int MAX_ROWS    = 750,
   parameter int CLR_CYCLES  = 4
) (
   input  logic        clk_133M_i,
   input  logic        rst_133i,
   input  logic        cmos_vsyn,
   input  logic [1:0]  cam_bank,
   input  logic [10:0] fifo_used,
   input  logic        wr_sdram_ack,
   output logic        wr_sdram_req,
   output logic [23:0] wr_sdram_add,
   output logic        clear_wrsdram_fifo,
   output logic        frame_done,
   output logic [12:0] rows_last,
   output logic        drop_flag
);

   typedef enum logic [2:0] {IDLE, CLR, WAIT, REQ, FULL} state_t;

   localparam logic [12:0] MAX_R    = 13'(MAX_ROWS);
   localparam logic [3:0]  CLR_INIT = 4'(CLR_CYCLES - 1);
   localparam logic [10:0] BURST_W  = 11'(BURST_WORDS);

   state_t      state, state_nx;
   logic        s1, s2, s3;
   logic        fs, ack_v;
   logic        pending, pending_nx;
   logic        fill_ok, fill_ok_nx;
   logic [3:0]  clr_cnt, clr_cnt_nx;
   logic [12:0] row, row_nx, row_inc;
   logic [1:0]  bank, bank_nx;
   logic        req_nx, clear_nx, frame_done_nx, drop_nx;
   logic [12:0] rows_last_nx;
   logic        boundary, enter_clr;

   assign fs           = s3 & ~s2;
   assign ack_v        = wr_sdram_ack & wr_sdram_req;
   assign wr_sdram_add = {bank, row, 9'd0};

   // Fill compare is only armed in the states that consume it, so the first
   // request after a clear (or after a burst) always sees one cycle of latency.
   assign fill_ok_nx = ((state == WAIT) || (state == FULL)) && (fifo_used >= BURST_W);

   always_comb begin
      state_nx      = state;
      pending_nx    = pending;
      clr_cnt_nx    = clr_cnt;
      row_nx        = row;
      bank_nx       = bank;
      req_nx        = wr_sdram_req;
      frame_done_nx = 1'b0;
      rows_last_nx  = rows_last;
      drop_nx       = drop_flag;
      boundary      = 1'b0;
      enter_clr     = 1'b0;
      row_inc       = row + 13'd1;

      case (state)
         IDLE: begin
            if (fs) enter_clr = 1'b1;
         end
         CLR: begin
            if (fs)                boundary   = 1'b1;
            else if (clr_cnt == '0) state_nx   = WAIT;
            else                   clr_cnt_nx = clr_cnt - 4'd1;
         end
         WAIT: begin
            if (fs) boundary = 1'b1;
            else if (fill_ok) begin
               req_nx   = 1'b1;
               state_nx = REQ;
            end
         end
         REQ: begin
            // An outstanding burst is never aborted; a frame start seen here
            // (or on the ack cycle itself) is deferred until the ack.
            if (ack_v) begin
               req_nx = 1'b0;
               if (pending || fs) begin
                  rows_last_nx  = row_inc;
                  frame_done_nx = 1'b1;
                  pending_nx    = 1'b0;
                  enter_clr     = 1'b1;
               end else begin
                  row_nx   = row_inc;
                  state_nx = (row_inc == MAX_R) ? FULL : WAIT;
               end
            end else if (fs) begin
               pending_nx = 1'b1;
            end
         end
         FULL: begin
            if (fill_ok) drop_nx  = 1'b1;
            if (fs)      boundary = 1'b1;
         end
         default: state_nx = IDLE;
      endcase

      if (boundary) begin
         rows_last_nx  = row;
         frame_done_nx = 1'b1;
         enter_clr     = 1'b1;
      end
      if (enter_clr) begin
         state_nx   = CLR;
         clr_cnt_nx = CLR_INIT;
         row_nx     = '0;
         bank_nx    = cam_bank;
      end
      clear_nx = (state_nx == CLR);
   end

   always_ff @(posedge clk_133M_i) begin
      if (!rst_133i) begin
         s1                 <= 1'b0;
         s2                 <= 1'b0;
         s3                 <= 1'b0;
         state              <= IDLE;
         pending            <= 1'b0;
         fill_ok            <= 1'b0;
         clr_cnt            <= '0;
         row                <= '0;
         bank               <= '0;
         wr_sdram_req       <= 1'b0;
         clear_wrsdram_fifo <= 1'b0;
         frame_done         <= 1'b0;
         rows_last          <= '0;
         drop_flag          <= 1'b0;
      end else begin
         s1                 <= cmos_vsyn;
         s2                 <= s1;
         s3                 <= s2;
         state              <= state_nx;
         pending            <= pending_nx;
         fill_ok            <= fill_ok_nx;
         clr_cnt            <= clr_cnt_nx;
         row                <= row_nx;
         bank               <= bank_nx;
         wr_sdram_req       <= req_nx;
         clear_wrsdram_fifo <= clear_nx;
         frame_done         <= frame_done_nx;
         rows_last          <= rows_last_nx;
         drop_flag          <= drop_nx;
      end
   end

endmodule

// File: tb/tb_cam_wr_sched.sv
// tb_cam_wr_sched -- directed bench for cam_wr_sched (MAX_ROWS overridden to 4).
module tb_cam_wr_sched;

   logic        clk = 1'b0;
   logic        rst_133i;
   logic        cmos_vsyn;
   logic [1:0]  cam_bank;
   logic [10:0] fifo_used;
   logic        wr_sdram_ack;
   logic        wr_sdram_req;
   logic [23:0] wr_sdram_add;
   logic        clear_wrsdram_fifo;
   logic        frame_done;
   logic [12:0] rows_last;
   logic        drop_flag;

   int checks = 0;
   int errors = 0;
   logic bad;

   cam_wr_sched #(.BURST_WORDS(512), .MAX_ROWS(4), .CLR_CYCLES(4)) dut (
      .clk_133M_i        (clk),
      .rst_133i          (rst_133i),
      .cmos_vsyn         (cmos_vsyn),
      .cam_bank          (cam_bank),
      .fifo_used         (fifo_used),
      .wr_sdram_ack      (wr_sdram_ack),
      .wr_sdram_req      (wr_sdram_req),
      .wr_sdram_add      (wr_sdram_add),
      .clear_wrsdram_fifo(clear_wrsdram_fifo),
      .frame_done        (frame_done),
      .rows_last         (rows_last),
      .drop_flag         (drop_flag)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input int maxc);
      int n = 0;
      while (wr_sdram_req !== 1'b1 && n < maxc) begin
         step(1);
         n++;
      end
      chk("req_wait", 32'(wr_sdram_req), 32'd1);
   endtask

   // One burst: request seen, address checked, ack after 20 cycles.
   task automatic burst(input logic [12:0] row, input logic [1:0] bank);
      logic dropped = 1'b0;
      wait_req(40);
      chk("burst_add", 32'(wr_sdram_add), 32'({bank, row, 9'd0}));
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (wr_sdram_req !== 1'b1) dropped = 1'b1;
      end
      chk("burst_hold", 32'(dropped), 32'd0);
      wr_sdram_ack = 1'b1;
      step(1);
      wr_sdram_ack = 1'b0;
      chk("burst_ack_req", 32'(wr_sdram_req), 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req"},  32'(wr_sdram_req), 32'd0);
      chk({tag, "_add"},  32'(wr_sdram_add), 32'd0);
      chk({tag, "_clr"},  32'(clear_wrsdram_fifo), 32'd0);
      chk({tag, "_fd"},   32'(frame_done), 32'd0);
      chk({tag, "_rows"}, 32'(rows_last), 32'd0);
      chk({tag, "_drop"}, 32'(drop_flag), 32'd0);
   endtask

   initial begin
      rst_133i = 1'b0; cmos_vsyn = 1'b1; cam_bank = 2'd1;
      fifo_used = 11'd511; wr_sdram_ack = 1'b0;
      step(3);
      chk_zero("reset");
      rst_133i = 1'b1;
      step(3);

      // Frame A, bank 1: clear window timing, fill threshold, first bursts.
      cmos_vsyn = 1'b0;
      step(2);
      chk("a_clr_pre", 32'(clear_wrsdram_fifo), 32'd0);
      step(1);
      chk("a_clr_on",  32'(clear_wrsdram_fifo), 32'd1);
      chk("a_add",     32'(wr_sdram_add), 32'h400000);
      chk("a_fd",      32'(frame_done), 32'd0);
      step(3);
      chk("a_clr_last", 32'(clear_wrsdram_fifo), 32'd1);
      step(1);
      chk("a_clr_off", 32'(clear_wrsdram_fifo), 32'd0);
      cmos_vsyn = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (wr_sdram_req !== 1'b0) bad = 1'b1;
      end
      chk("no_req_511", 32'(bad), 32'd0);
      fifo_used = 11'd512;
      step(1);
      chk("req_512_lat1", 32'(wr_sdram_req), 32'd0);
      step(1);
      chk("req_512_lat2", 32'(wr_sdram_req), 32'd1);
      chk("row0_add", 32'(wr_sdram_add), 32'h400000);
      step(19);
      chk("req_hold", 32'(wr_sdram_req), 32'd1);
      wr_sdram_ack = 1'b1;
      step(1);
      wr_sdram_ack = 1'b0;
      chk("ack_req_low", 32'(wr_sdram_req), 32'd0);
      chk("row1_add",    32'(wr_sdram_add), 32'h400200);
      step(1);
      chk("gap_req_low", 32'(wr_sdram_req), 32'd0);
      step(1);
      chk("req_again",   32'(wr_sdram_req), 32'd1);
      burst(13'd1, 2'd1);
      burst(13'd2, 2'd1);
      burst(13'd3, 2'd1);
      chk("full_add",   32'(wr_sdram_add), 32'h400800);
      chk("drop_early", 32'(drop_flag), 32'd0);
      step(3);
      chk("drop_set",   32'(drop_flag), 32'd1);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (wr_sdram_req !== 1'b0) bad = 1'b1;
      end
      chk("full_no_req", 32'(bad), 32'd0);

      // Frame B, bank 2: boundary from FULL.
      cam_bank = 2'd2; fifo_used = 11'd600;
      cmos_vsyn = 1'b0;
      step(2);
      chk("b_fd_pre",  32'(frame_done), 32'd0);
      step(1);
      chk("b_fd",      32'(frame_done), 32'd1);
      chk("b_rows",    32'(rows_last), 32'd4);
      chk("b_add",     32'(wr_sdram_add), 32'h800000);
      chk("b_clr",     32'(clear_wrsdram_fifo), 32'd1);
      step(1);
      chk("b_fd_pulse", 32'(frame_done), 32'd0);
      chk("drop_sticky", 32'(drop_flag), 32'd1);
      cmos_vsyn = 1'b1;
      burst(13'd0, 2'd2);

      // Two frame starts during an outstanding burst, ack 30 cycles later.
      wait_req(40);
      cam_bank = 2'd3;
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 1)  cmos_vsyn = 1'b0;
         if (i == 8)  cmos_vsyn = 1'b1;
         if (i == 14) cmos_vsyn = 1'b0;
         step(1);
         if (wr_sdram_req !== 1'b1 || frame_done !== 1'b0) bad = 1'b1;
      end
      chk("pend_hold", 32'(bad), 32'd0);
      wr_sdram_ack = 1'b1;
      step(1);
      wr_sdram_ack = 1'b0;
      chk("pend_req",  32'(wr_sdram_req), 32'd0);
      chk("pend_fd",   32'(frame_done), 32'd1);
      chk("pend_rows", 32'(rows_last), 32'd2);
      chk("pend_clr",  32'(clear_wrsdram_fifo), 32'd1);
      chk("pend_add",  32'(wr_sdram_add), 32'hC00000);
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step(1);
         if (frame_done !== 1'b0) bad = 1'b1;
      end
      chk("pend_single", 32'(bad), 32'd0);

      // Reset mid-burst, stale ack, resume only on a new frame start.
      wait_req(40);
      chk("c_add", 32'(wr_sdram_add), 32'hC00000);
      step(2);
      rst_133i = 1'b0;
      step(1);
      chk_zero("midrst");
      rst_133i = 1'b1;
      wr_sdram_ack = 1'b1;
      step(1);
      wr_sdram_ack = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (wr_sdram_req !== 1'b0 || clear_wrsdram_fifo !== 1'b0) bad = 1'b1;
      end
      chk("rst_idle", 32'(bad), 32'd0);
      cmos_vsyn = 1'b1;
      step(5);
      cam_bank = 2'd1;
      cmos_vsyn = 1'b0;
      step(3);
      chk("r_clr", 32'(clear_wrsdram_fifo), 32'd1);
      chk("r_add", 32'(wr_sdram_add), 32'h400000);
      chk("r_fd",  32'(frame_done), 32'd0);
      wait_req(40);
      chk("r_req_add", 32'(wr_sdram_add), 32'h400000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
